// File: rtl/serial_paralelo_align_if.sv
// Serial receiver bus: one-bit line in, aligned byte stream and status out.
interface serial_paralelo_align_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       word_strobe;

  // Line driver / consumer side
  modport master (
    output data_in,
    input  data_out, valid_out, active, word_strobe
  );

  // Receiver side
  modport slave (
    input  data_in,
    output data_out, valid_out, active, word_strobe
  );
endinterface

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel receiver that hunts for a comma character, confirms
// byte alignment over LOCK_COUNT consecutive commas, then emits non-comma bytes.
module serial_paralelo_align #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                          clk_8f,
  input  logic                          reset,
  serial_paralelo_align_if.slave        bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {
    HUNT,
    COUNT,
    LOCKED
  } state_t;

  state_t           state;
  // Only the seven most recent bits are ever read; the eighth is the incoming bit.
  logic [6:0]       sr;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bc_cnt;
  logic [7:0]       w;
  logic             boundary;
  logic             is_comma;
  logic [CNT_W-1:0] bc_next;

  // Candidate byte ends with the bit being sampled on this edge
  assign w        = {sr, bus.data_in};
  assign is_comma = (w == COMMA);
  assign boundary = (bit_cnt == BIT_W'(7));
  assign bc_next  = bc_cnt + CNT_W'(1);

  // Alignment state machine, bit/comma counters and registered outputs
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state           <= HUNT;
      sr              <= '0;
      bit_cnt         <= '0;
      bc_cnt          <= '0;
      bus.data_out    <= 8'h00;
      bus.valid_out   <= 1'b0;
      bus.active      <= 1'b0;
      bus.word_strobe <= 1'b0;
    end else begin
      sr              <= w[6:0];
      bus.valid_out   <= 1'b0;
      bus.word_strobe <= 1'b0;
      case (state)
        HUNT: begin
          // Any comma, even one straddling shifted data, starts a count
          if (is_comma) begin
            bit_cnt <= '0;
            bc_cnt  <= CNT_W'(1);
            if (LOCK_COUNT == 1) begin
              state      <= LOCKED;
              bus.active <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_next;
              if (bc_next == CNT_W'(LOCK_COUNT)) begin
                state      <= LOCKED;
                bus.active <= 1'b1;
              end
            end else begin
              state  <= HUNT;
              bc_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          // Lock is sticky; only reset leaves this state
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (boundary) begin
            bus.word_strobe <= 1'b1;
            if (!is_comma) begin
              bus.data_out  <= w;
              bus.valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Bench for serial_paralelo_align: scripted serial streams, scoreboard of expected bytes.
module tb_serial_paralelo_align;

  localparam logic [7:0] COMMA = 8'hBC;

  logic clk_8f = 1'b0;
  logic reset  = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  logic [7:0] exp_q[$];

  serial_paralelo_align_if bus_if ();

  serial_paralelo_align #(.COMMA(COMMA), .LOCK_COUNT(4)) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus_if)
  );

  always #5 clk_8f = ~clk_8f;

  // Drive one bit, let the edge happen, and retire any produced byte against the scoreboard
  task automatic send_bit(input logic b);
    logic [7:0] exp;
    bus_if.data_in = b;
    @(posedge clk_8f);
    #1;
    if (bus_if.valid_out === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_unexpected: data_out=%h with no byte expected", bus_if.data_out);
      end else begin
        exp = exp_q.pop_front();
        if (bus_if.data_out !== exp) begin
          bad++;
          $display("FAIL scoreboard_data: data_out=%h expected %h", bus_if.data_out, exp);
        end
      end
    end
  endtask

  // Bits 7..1 of a byte, MSB first
  task automatic send_head(input logic [7:0] b);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_head(b);
    send_bit(b[0]);
  endtask

  // Hold reset for n edges with random line data, checking outputs are zero on each
  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_if.data_in = 1'($urandom);
      @(posedge clk_8f);
      #1;
      total++;
      if ({bus_if.data_out, bus_if.valid_out, bus_if.active, bus_if.word_strobe} !== 11'd0) begin
        bad++;
        $display("FAIL reset_outputs: edge %0d data=%h valid=%b active=%b strobe=%b, required all 0",
                 i, bus_if.data_out, bus_if.valid_out, bus_if.active, bus_if.word_strobe);
      end
    end
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected bytes never produced, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset(10);
    send_bit(1'b0);
    total++;
    if ({bus_if.data_out, bus_if.valid_out, bus_if.active, bus_if.word_strobe} !== 11'd0) begin
      bad++;
      $display("FAIL reset_release: outputs %h/%b/%b/%b, required all 0",
               bus_if.data_out, bus_if.valid_out, bus_if.active, bus_if.word_strobe);
    end
  endtask

  task automatic test_aligned();
    logic [7:0] c;
    c = COMMA;
    do_reset(2);
    repeat (3) send_byte(c);
    send_head(c);
    total++;
    if (bus_if.active !== 1'b0) begin
      bad++;
      $display("FAIL aligned_active_bit30: active=%b required 0", bus_if.active);
    end
    send_bit(c[0]);
    total++;
    if ({bus_if.active, bus_if.valid_out, bus_if.word_strobe} !== 3'b100) begin
      bad++;
      $display("FAIL aligned_lock_bit31: active/valid/strobe=%b required 100",
               {bus_if.active, bus_if.valid_out, bus_if.word_strobe});
    end
    exp_q.push_back(8'hAA);
    send_head(8'hAA);
    total++;
    if (bus_if.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL aligned_valid_bit38: valid=%b required 0", bus_if.valid_out);
    end
    send_bit(1'b0);
    total++;
    if ({bus_if.valid_out, bus_if.word_strobe} !== 2'b11) begin
      bad++;
      $display("FAIL aligned_valid_bit39: valid/strobe=%b required 11", {bus_if.valid_out, bus_if.word_strobe});
    end
    exp_q.push_back(8'h3A);
    send_byte(8'h3A);
    total++;
    if ({bus_if.data_out, bus_if.valid_out} !== {8'h3A, 1'b1}) begin
      bad++;
      $display("FAIL aligned_bit47: data=%h valid=%b required 3a/1", bus_if.data_out, bus_if.valid_out);
    end
    check_drained("aligned");
  endtask

  task automatic test_junk();
    logic [7:0] c;
    c = COMMA;
    do_reset(2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (3) send_byte(c);
    send_head(c);
    total++;
    if (bus_if.active !== 1'b0) begin
      bad++;
      $display("FAIL junk_active_early: active=%b required 0", bus_if.active);
    end
    send_bit(c[0]);
    total++;
    if (bus_if.active !== 1'b1) begin
      bad++;
      $display("FAIL junk_lock: active=%b required 1", bus_if.active);
    end
    exp_q.push_back(8'h90);
    send_byte(8'h90);
    total++;
    if ({bus_if.data_out, bus_if.valid_out} !== {8'h90, 1'b1}) begin
      bad++;
      $display("FAIL junk_byte: data=%h valid=%b required 90/1", bus_if.data_out, bus_if.valid_out);
    end
    check_drained("junk");
  endtask

  task automatic test_false_lock();
    logic [7:0] c;
    c = COMMA;
    do_reset(2);
    send_byte(c);
    send_byte(c);
    send_byte(8'h55);
    total++;
    if (bus_if.active !== 1'b0) begin
      bad++;
      $display("FAIL false_lock_after55: active=%b required 0", bus_if.active);
    end
    repeat (3) send_byte(c);
    send_head(c);
    total++;
    if (bus_if.active !== 1'b0) begin
      bad++;
      $display("FAIL false_lock_early: active=%b required 0", bus_if.active);
    end
    send_bit(c[0]);
    total++;
    if (bus_if.active !== 1'b1) begin
      bad++;
      $display("FAIL false_lock_relock: active=%b required 1", bus_if.active);
    end
    exp_q.push_back(8'h0A);
    send_byte(8'h0A);
    check_drained("false_lock");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      if (b == COMMA) b = 8'h3C;
      exp_q.push_back(b);
      send_byte(b);
      total++;
      if ({bus_if.valid_out, bus_if.word_strobe, bus_if.active} !== 3'b111) begin
        bad++;
        $display("FAIL back_to_back_flags: byte %0d valid/strobe/active=%b required 111",
                 k, {bus_if.valid_out, bus_if.word_strobe, bus_if.active});
      end
    end
    check_drained("back_to_back");
  endtask

  task automatic test_comma_hold();
    logic [7:0] c;
    logic [9:0] want;
    c = COMMA;
    exp_q.push_back(8'h5D);
    send_byte(8'h5D);
    for (int k = 0; k < 3; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(c[i]);
        want = {(i == 0), 1'b0, 8'h5D};
        total++;
        if ({bus_if.word_strobe, bus_if.valid_out, bus_if.data_out} !== want) begin
          bad++;
          $display("FAIL comma_hold: comma %0d bit %0d strobe/valid/data=%b/%b/%h required %b/%b/%h",
                   k, 7 - i, bus_if.word_strobe, bus_if.valid_out, bus_if.data_out,
                   want[9], want[8], want[7:0]);
        end
      end
    end
    check_drained("comma_hold");
  endtask

  task automatic test_reset_locked();
    logic [7:0] c;
    c = COMMA;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    bus_if.data_in = 1'b0;
    @(posedge clk_8f);
    #1;
    total++;
    if ({bus_if.data_out, bus_if.valid_out, bus_if.active, bus_if.word_strobe} !== 11'd0) begin
      bad++;
      $display("FAIL reset_locked_outputs: %h/%b/%b/%b required all 0",
               bus_if.data_out, bus_if.valid_out, bus_if.active, bus_if.word_strobe);
    end
    reset = 1'b1;
    repeat (3) send_byte(c);
    send_head(c);
    total++;
    if (bus_if.active !== 1'b0) begin
      bad++;
      $display("FAIL reset_locked_early: active=%b required 0", bus_if.active);
    end
    send_bit(c[0]);
    total++;
    if ({bus_if.active, bus_if.valid_out} !== 2'b10) begin
      bad++;
      $display("FAIL reset_locked_relock: active/valid=%b required 10", {bus_if.active, bus_if.valid_out});
    end
    exp_q.push_back(8'h42);
    send_byte(8'h42);
    check_drained("reset_locked");
  endtask

  initial begin
    bus_if.data_in = 1'b0;
    test_reset();
    test_aligned();
    test_junk();
    test_false_lock();
    test_back_to_back();
    test_comma_hold();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_align.md
SERIAL_PARALELO_ALIGN -- requirements
Module: serial_paralelo_align

Interface
REQ-001 The block SHALL have parameter COMMA, default 8'hBC, which is the idle/alignment character.
REQ-002 The block SHALL have parameter LOCK_COUNT, default 4, legal range 1..15, which is the number of consecutive aligned commas needed for lock.
REQ-003 Port clk_8f SHALL be input, 1 bit: the serial bit clock and the only clock; all logic is on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit: synchronous, active-low reset (0 = reset asserted).
REQ-005 Port data_in SHALL be input, 1 bit: serial line, one bit per clk_8f edge, MSB first.
REQ-006 Port data_out SHALL be output, 8 bits: last received non-comma byte.
REQ-007 Port valid_out SHALL be output, 1 bit: data_out carries a byte completed on this boundary.
REQ-008 Port active SHALL be output, 1 bit: the receiver is byte-aligned (locked).
REQ-009 Port word_strobe SHALL be output, 1 bit: one-cycle pulse at each byte boundary while locked.

Function
REQ-010 Every edge, shift register sr[7:0] SHALL load {sr[6:0], data_in}; the candidate byte W SHALL be {sr[6:0], data_in}.
REQ-011 State machine states SHALL be HUNT, COUNT and LOCKED, with a 3-bit bit counter bit_cnt and a 4-bit comma counter bc_cnt.
REQ-012 In HUNT, W SHALL be compared with COMMA on every edge; on a match, bit_cnt<=0, bc_cnt<=1 and state<=COUNT, or state<=LOCKED if LOCK_COUNT==1.
REQ-013 Outside HUNT, bit_cnt SHALL increment mod 8 each edge; a byte boundary is an edge with bit_cnt==7, which samples the LSB.
REQ-014 In COUNT at a boundary, if W==COMMA then bc_cnt SHALL increment.
REQ-015 In COUNT, when bc_cnt reaches LOCK_COUNT the block SHALL set state<=LOCKED and active<=1 on that same edge.
REQ-016 In COUNT at a boundary, if W!=COMMA the block SHALL set state<=HUNT and bc_cnt<=0, and active SHALL stay 0.
REQ-017 In COUNT, no output other than active SHALL change.
REQ-018 In LOCKED at a boundary, word_strobe SHALL be 1 for exactly that one cycle.
REQ-019 In LOCKED at a boundary with W!=COMMA, the block SHALL set data_out<=W and valid_out<=1.
REQ-020 In LOCKED at a boundary with W==COMMA, the block SHALL set valid_out<=0 and data_out SHALL hold its value.
REQ-021 In LOCKED at a non-boundary edge, valid_out and word_strobe SHALL be 0 and data_out SHALL hold.
REQ-022 Latency: data_out and valid_out SHALL be registered on the same edge that samples the byte's LSB, with no extra pipeline stage.
REQ-023 The comma that completes lock SHALL NOT be output: valid_out=0 and word_strobe=0 on that edge.
REQ-024 LOCKED SHALL be left only by reset; data errors do not drop lock.
REQ-025 bc_cnt SHALL saturate at LOCK_COUNT and never wrap.
REQ-026 In HUNT, a false comma formed across shifted data SHALL be accepted; REQ-016 recovers from it at the next boundary.

Reset
REQ-027 When reset==0 on an edge, the block SHALL set sr=0, bit_cnt=0, bc_cnt=0, state=HUNT, data_out=8'h00, valid_out=0, active=0 and word_strobe=0, overriding all other behaviour, including mid-byte and while LOCKED.
REQ-028 On the first edge with reset==1, the block SHALL operate normally, starting in HUNT with sr=0.

Verification
REQ-029 Reset low for 10 edges with random data_in -> all outputs SHALL be 0 throughout.
REQ-030 BC x4 then 8'hAA, 8'h3A, aligned from the first bit -> active SHALL rise on bit 31, then data_out=AA/valid_out=1 on bit 39 and data_out=3A on bit 47.
REQ-031 3 junk bits, then BC x4, then 8'h90 -> lock SHALL occur at the end of the 4th BC, then data_out=90, valid_out=1.
REQ-032 BC, BC, 8'h55, then BC x4, 8'h0A -> the 55 SHALL return the block to HUNT with active=0, then it SHALL lock and output 0A.
REQ-033 When locked, 8'h5D then BC x3 -> data_out SHALL stay 5D with valid_out=0 and word_strobe SHALL pulse every 8 edges.
REQ-034 When locked mid-byte, reset low for 1 edge -> all outputs SHALL be 0 on the next cycle, and relock SHALL need LOCK_COUNT new commas.
